// File: rtl/enemy_hit_judge_pkg.sv
// ============================================================================
// Module  : enemy_hit_judge_pkg
// Purpose : Shared game definitions for the bullet/enemy stages: enemy state
//           encoding, display colours, bullet-space vertical offset and the
//           bullet box size.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package enemy_hit_judge_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE   = 2'd0,
    ST_EXPLODE = 2'd1,
    ST_DEAD    = 2'd2
  } enemy_state_t;

  localparam logic [11:0] RGB_GREEN  = 12'h0F0;
  localparam logic [11:0] RGB_ORANGE = 12'hF80;
  localparam logic [11:0] RGB_RED    = 12'hF00;
  localparam logic [11:0] RGB_BLACK  = 12'h000;

  // Bullet coordinates live in a space shifted down by this amount.
  localparam int Y_OFF    = 480;
  localparam int BULLET_W = 10;
  localparam int BULLET_H = 40;

  localparam int COORD_W = 10;
  localparam int WIDE_W  = 11;

  // Zero-extend a screen coordinate so sums with box sizes never wrap.
  function automatic logic [WIDE_W-1:0] widen(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_hit_judge_if.sv
// ============================================================================
// Module  : enemy_hit_judge_if
// Purpose : Bullet stage <-> enemy judge link. The bullet stage (master)
//           supplies position and existence; the judge (slave) returns boom.
// Ports   : b_x, b_y (bullet top-left, bullet space), bullet_exist, boom
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface enemy_hit_judge_if;
  import enemy_hit_judge_pkg::*;

  logic [COORD_W-1:0] b_x;
  logic [COORD_W-1:0] b_y;
  logic               bullet_exist;
  logic               boom;

  modport master (
    output b_x,
    output b_y,
    output bullet_exist,
    input  boom
  );

  modport slave (
    input  b_x,
    input  b_y,
    input  bullet_exist,
    output boom
  );

endinterface

`default_nettype wire

// File: rtl/enemy_hit_judge_box_overlap.sv
// ============================================================================
// Module  : enemy_hit_judge_box_overlap
// Purpose : Axis-aligned overlap test between box A (A_W x A_H at a_x,a_y)
//           and box B (B_W x B_H at b_x,b_y). Right/bottom edges exclusive.
//           Coordinates are 11 bits wide so callers can add offsets freely.
// Ports   : a_x, a_y, b_x, b_y (11-bit top-left corners), overlap (out)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module enemy_hit_judge_box_overlap #(
  parameter int A_W = 1,
  parameter int A_H = 1,
  parameter int B_W = 1,
  parameter int B_H = 1
) (
  input  wire logic [10:0] a_x,
  input  wire logic [10:0] a_y,
  input  wire logic [10:0] b_x,
  input  wire logic [10:0] b_y,
  output logic             overlap
);

  localparam logic [10:0] AW = 11'(A_W);
  localparam logic [10:0] AH = 11'(A_H);
  localparam logic [10:0] BW = 11'(B_W);
  localparam logic [10:0] BH = 11'(B_H);

  always_comb begin
    overlap = (a_x < b_x + BW) && (b_x < a_x + AW) &&
              (a_y < b_y + BH) && (b_y < a_y + AH);
  end

endmodule

`default_nettype wire

// File: rtl/enemy_hit_judge.sv
// ============================================================================
// Module  : enemy_hit_judge
// Purpose : Judges player-bullet collision with one enemy once per frame,
//           raises boom to the bullet stage, keeps a saturating score and
//           walks the enemy through ALIVE -> EXPLODE -> DEAD -> ALIVE. Also
//           provides the enemy pixel enable/colour for the display mixer.
// Ports   : clk, rst (async, active high), frame_tick, bus (slave: b_x, b_y,
//           bullet_exist in / boom out), e_x, e_y, x, y in; enemy_alive,
//           enemy_en, enemy_rgb[11:0], score[9:0] out
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module enemy_hit_judge #(
  parameter int ENEMY_W        = 40,
  parameter int ENEMY_H        = 40,
  parameter int Y_OFF          = enemy_hit_judge_pkg::Y_OFF,
  parameter int EXPLODE_FRAMES = 16,
  parameter int RESPAWN_FRAMES = 60,
  parameter int SCORE_MAX      = 999
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       frame_tick,
  enemy_hit_judge_if.slave bus,
  input  wire logic [9:0] e_x,
  input  wire logic [9:0] e_y,
  input  wire logic [9:0] x,
  input  wire logic [9:0] y,
  output logic            enemy_alive,
  output logic            enemy_en,
  output logic [11:0]     enemy_rgb,
  output logic [9:0]      score
);
  import enemy_hit_judge_pkg::*;

  localparam int CNT_MAX = (EXPLODE_FRAMES > RESPAWN_FRAMES) ? EXPLODE_FRAMES : RESPAWN_FRAMES;
  // At least 2 bits: the explosion colour alternates on bit 1.
  localparam int CNT_W   = ($clog2(CNT_MAX) < 2) ? 2 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] EXPLODE_LAST = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [CNT_W-1:0] RESPAWN_LAST = CNT_W'(RESPAWN_FRAMES - 1);
  localparam logic [9:0]       SCORE_TOP    = 10'(SCORE_MAX);
  localparam logic [10:0]      Y_OFF_W      = 11'(Y_OFF);

  enemy_state_t     state;
  logic [CNT_W-1:0] frame_cnt;
  logic             boom_reg;

  logic [10:0] bullet_x_w;
  logic [10:0] bullet_y_w;
  logic [10:0] enemy_x_w;
  logic [10:0] enemy_y_scr_w;
  logic [10:0] enemy_y_blt_w;
  logic        bullet_overlap;
  logic        bullet_on_screen;
  logic        pixel_in_box;
  logic        hit;

  always_comb begin
    bullet_x_w    = widen(bus.b_x);
    bullet_y_w    = widen(bus.b_y);
    enemy_x_w     = widen(e_x);
    enemy_y_scr_w = widen(e_y);
    // Enemy moved into bullet space so both boxes share one coordinate frame.
    enemy_y_blt_w = widen(e_y) + Y_OFF_W;
  end

  enemy_hit_judge_box_overlap #(
    .A_W (BULLET_W),
    .A_H (BULLET_H),
    .B_W (ENEMY_W),
    .B_H (ENEMY_H)
  ) u_bullet_overlap (
    .a_x     (bullet_x_w),
    .a_y     (bullet_y_w),
    .b_x     (enemy_x_w),
    .b_y     (enemy_y_blt_w),
    .overlap (bullet_overlap)
  );

  // A 1x1 box at the scan pixel turns the overlap test into point-in-box.
  enemy_hit_judge_box_overlap #(
    .A_W (1),
    .A_H (1),
    .B_W (ENEMY_W),
    .B_H (ENEMY_H)
  ) u_pixel_overlap (
    .a_x     (widen(x)),
    .a_y     (widen(y)),
    .b_x     (enemy_x_w),
    .b_y     (enemy_y_scr_w),
    .overlap (pixel_in_box)
  );

  always_comb begin
    bullet_on_screen = (bullet_y_w > Y_OFF_W);
    hit = frame_tick && (state == ST_ALIVE) && bus.bullet_exist && !boom_reg &&
          bullet_overlap && bullet_on_screen;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ALIVE;
      frame_cnt <= '0;
      score     <= '0;
      boom_reg  <= 1'b0;
    end else begin
      // boom is held until the slower bullet stage withdraws its bullet;
      // a hit is never judged while boom is high, so set/clear cannot clash.
      if (boom_reg && !bus.bullet_exist) begin
        boom_reg <= 1'b0;
      end else if (hit) begin
        boom_reg <= 1'b1;
      end

      case (state)
        ST_ALIVE: begin
          if (hit) begin
            state     <= ST_EXPLODE;
            frame_cnt <= '0;
            if (score != SCORE_TOP) begin
              score <= score + 10'd1;
            end
          end
        end
        ST_EXPLODE: begin
          if (frame_tick) begin
            if (frame_cnt == EXPLODE_LAST) begin
              state     <= ST_DEAD;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        ST_DEAD: begin
          if (frame_tick) begin
            if (frame_cnt == RESPAWN_LAST) begin
              state     <= ST_ALIVE;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_ALIVE;
          frame_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.boom    = boom_reg;
  assign enemy_alive = (state == ST_ALIVE);

  always_comb begin
    enemy_en  = pixel_in_box && (state != ST_DEAD);
    enemy_rgb = RGB_BLACK;
    if (enemy_en) begin
      if (state == ST_ALIVE) begin
        enemy_rgb = RGB_GREEN;
      end else begin
        enemy_rgb = frame_cnt[1] ? RGB_RED : RGB_ORANGE;
      end
    end
  end

endmodule

`default_nettype wire
